// File: rtl/sauria_drain_pkg.sv
// Shared types and defaults for the psum drain path.
package sauria_drain_pkg;

  localparam int unsigned FP_W_DEFAULT   = 16;
  localparam int unsigned N_ROWS_DEFAULT = 8;

  typedef enum logic {
    DRAIN_IDLE   = 1'b0,
    DRAIN_ACTIVE = 1'b1
  } drain_state_e;

  // Row-index width, never below one bit so N_ROWS=1 still has a port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psum_drain_unit_if.sv
// Snapshot-in / element-stream-out bundle of the psum drain unit.
interface psum_drain_unit_if
  import sauria_drain_pkg::*;
#(
  parameter int unsigned FP_W   = FP_W_DEFAULT,
  parameter int unsigned N_ROWS = N_ROWS_DEFAULT,
  parameter int unsigned IDX_W  = idx_width(N_ROWS)
);

  logic                   i_snap_valid;
  logic [N_ROWS*FP_W-1:0] i_psums;
  logic                   o_snap_ready;
  logic                   o_stall;
  logic [FP_W-1:0]        o_data;
  logic                   o_valid;
  logic                   i_ready;
  logic                   o_last;
  logic [IDX_W-1:0]       o_row_idx;
  logic                   o_busy;

  // Drain unit side.
  modport master (
    input  i_snap_valid, i_psums, i_ready,
    output o_snap_ready, o_stall, o_data, o_valid, o_last, o_row_idx, o_busy
  );

  // Array controller / SRAM feeder side.
  modport slave (
    output i_snap_valid, i_psums, i_ready,
    input  o_snap_ready, o_stall, o_data, o_valid, o_last, o_row_idx, o_busy
  );

endinterface

// File: rtl/psum_shift_buf.sv
// Parallel-load column buffer that shifts toward row 0; row 0 is the head.
module psum_shift_buf #(
  parameter int unsigned FP_W   = 16,
  parameter int unsigned N_ROWS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   shift,
  input  logic [N_ROWS*FP_W-1:0] din,
  output logic [FP_W-1:0]        head
);

  localparam int unsigned BUF_W = N_ROWS * FP_W;

  logic [BUF_W-1:0] buf_q;

  // Load has priority over shift; vacated top row fills with zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else if (load) begin
      buf_q <= din;
    end else if (shift) begin
      buf_q <= buf_q >> FP_W;
    end
  end

  assign head = buf_q[FP_W-1:0];

endmodule

// File: rtl/psum_drain_unit.sv
// Captures a column of psums and streams it row by row, with one pending snapshot.
module psum_drain_unit
  import sauria_drain_pkg::*;
#(
  parameter int unsigned FP_W   = FP_W_DEFAULT,
  parameter int unsigned N_ROWS = N_ROWS_DEFAULT,
  parameter int unsigned IDX_W  = idx_width(N_ROWS)
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  psum_drain_unit_if.master bus
);

  localparam int unsigned BUF_W = N_ROWS * FP_W;

  drain_state_e     state_q, state_d;
  logic [IDX_W-1:0] row_idx_q, row_idx_d;
  logic [BUF_W-1:0] pend_q;
  logic             pend_full_q, pend_full_d;
  logic             pend_load;
  logic             act_load;
  logic             act_shift;
  logic [BUF_W-1:0] act_din;
  logic [FP_W-1:0]  act_head;

  logic accept;
  logic hs;
  logic at_last;

  assign accept  = bus.i_snap_valid & ~pend_full_q;
  assign hs      = (state_q == DRAIN_ACTIVE) & bus.i_ready;
  assign at_last = (row_idx_q == IDX_W'(N_ROWS - 1));

  // Next state, row index, pending flag and buffer load/shift controls.
  always_comb begin
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    pend_full_d = pend_full_q;
    pend_load   = 1'b0;
    act_load    = 1'b0;
    act_shift   = 1'b0;
    act_din     = bus.i_psums;

    unique case (state_q)
      DRAIN_IDLE: begin
        if (accept) begin
          act_load  = 1'b1;
          row_idx_d = '0;
          state_d   = DRAIN_ACTIVE;
        end
      end
      DRAIN_ACTIVE: begin
        if (hs && at_last) begin
          row_idx_d = '0;
          if (pend_full_q) begin
            // Pending snapshot follows without a bubble; ready is low so no accept.
            act_load    = 1'b1;
            act_din     = pend_q;
            pend_full_d = 1'b0;
          end else if (accept) begin
            act_load = 1'b1;
          end else begin
            state_d = DRAIN_IDLE;
          end
        end else begin
          if (hs) begin
            act_shift = 1'b1;
            row_idx_d = row_idx_q + IDX_W'(1);
          end
          if (accept) begin
            pend_load   = 1'b1;
            pend_full_d = 1'b1;
          end
        end
      end
      default: state_d = DRAIN_IDLE;
    endcase
  end

  // FSM, row index and pending-full registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= DRAIN_IDLE;
      row_idx_q   <= '0;
      pend_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_idx_q   <= row_idx_d;
      pend_full_q <= pend_full_d;
    end
  end

  // Pending snapshot storage.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pend_q <= '0;
    end else if (pend_load) begin
      pend_q <= bus.i_psums;
    end
  end

  psum_shift_buf #(
    .FP_W   (FP_W),
    .N_ROWS (N_ROWS)
  ) u_active_buf (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .load  (act_load),
    .shift (act_shift),
    .din   (act_din),
    .head  (act_head)
  );

  assign bus.o_valid      = (state_q == DRAIN_ACTIVE);
  assign bus.o_data       = act_head;
  assign bus.o_row_idx    = row_idx_q;
  assign bus.o_last       = (state_q == DRAIN_ACTIVE) & at_last;
  assign bus.o_snap_ready = ~pend_full_q;
  assign bus.o_stall      = bus.i_snap_valid & pend_full_q;
  assign bus.o_busy       = (state_q == DRAIN_ACTIVE) | pend_full_q;

endmodule
